// File: rtl/fp_pkg.sv
// Shared floating-point operand classification types.
// Class enum, flag bundle and a flag-to-class helper.
package fp_pkg;

  typedef enum logic [2:0] {
    CLS_NORM,
    CLS_ZERO,
    CLS_SUB,
    CLS_INF,
    CLS_QNAN,
    CLS_SNAN
  } fp_class_e;

  typedef struct packed {
    logic zero;
    logic inf;
    logic nan;
    logic snan;
  } fp_flags_t;

  // An all-ones exponent wins over an all-zero one, so the
  // illegal e_inf & ez pairing lands in INF or NaN.
  function automatic fp_class_e fp_classify(
    input logic e_inf,
    input logic h_1,
    input logic fz,
    input logic ez
  );
    fp_class_e cls;
    if (e_inf) begin
      if (fz)       cls = CLS_INF;
      else if (h_1) cls = CLS_QNAN;
      else          cls = CLS_SNAN;
    end else if (ez) begin
      cls = fz ? CLS_ZERO : CLS_SUB;
    end else begin
      cls = CLS_NORM;
    end
    return cls;
  endfunction

endpackage

// File: rtl/fp_class_decode.sv
// Combinational IEEE-754 special-class flag decode.
// In: e_inf, h_1, fz, ez field flags. Out: flags (zero/inf/nan/snan).
module fp_class_decode
  import fp_pkg::*;
(
  input  logic      e_inf,
  input  logic      h_1,
  input  logic      fz,
  input  logic      ez,
  output fp_flags_t flags
);

  always_comb begin
    flags      = '0;
    flags.inf  = e_inf & fz;
    flags.nan  = e_inf & ~fz;
    flags.snan = e_inf & ~fz & ~h_1;
    flags.zero = ez & fz & ~e_inf;
  end

endmodule

// File: rtl/fp_exception_classifier.sv
// Registered exception classifier for the FP adder operand path.
// In: clk, rst_n, in_valid, e_inf, h_1, fz, ez. Out: out_valid, ZERO, INF, NAN, SNAN.
module fp_exception_classifier
  import fp_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic e_inf,
  input  logic h_1,
  input  logic fz,
  input  logic ez,
  output logic out_valid,
  output logic ZERO,
  output logic INF,
  output logic NAN,
  output logic SNAN
);

  fp_flags_t flags_d;
  fp_flags_t flags_q;
  logic      valid_q;

  fp_class_decode u_dec (
    .e_inf (e_inf),
    .h_1   (h_1),
    .fz    (fz),
    .ez    (ez),
    .flags (flags_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      flags_q <= '0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) flags_q <= flags_d;
    end
  end

  assign out_valid = valid_q;
  assign ZERO      = flags_q.zero;
  assign INF       = flags_q.inf;
  assign NAN       = flags_q.nan;
  assign SNAN      = flags_q.snan;

endmodule

// File: tb/tb_fp_exception_classifier.sv
// Self-checking bench for fp_exception_classifier.
// Directed table, hold/stream/reset sequences, exhaustive and random checks.
module tb_fp_exception_classifier;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic e_inf, h_1, fz, ez;
  logic out_valid, ZERO, INF, NAN, SNAN;

  int checks = 0;
  int errors = 0;

  // reference state: {zero,inf,nan,snan}
  logic [3:0] ref_flags;
  logic       ref_valid;

  always #5 clk = ~clk;

  fp_exception_classifier dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .e_inf     (e_inf),
    .h_1       (h_1),
    .fz        (fz),
    .ez        (ez),
    .out_valid (out_valid),
    .ZERO      (ZERO),
    .INF       (INF),
    .NAN       (NAN),
    .SNAN      (SNAN)
  );

  typedef struct {
    logic [3:0] in;   // {e_inf,h_1,fz,ez}
    logic [3:0] exp;  // {zero,inf,nan,snan}
  } vec_t;

  vec_t tbl[9];

  // Reference: classify the operand by IEEE meaning, then flag it.
  function automatic logic [3:0] model(input logic [3:0] in);
    bit max_exp  = in[3];
    bit quiet    = in[2];
    bit frac_nz  = !in[1];
    bit zero_exp = in[0];
    if (max_exp) begin
      if (!frac_nz)   return 4'b0100;
      else if (quiet) return 4'b0010;
      else            return 4'b0011;
    end
    if (zero_exp && !frac_nz) return 4'b1000;
    return 4'b0000;
  endfunction

  function automatic logic [4:0] dut_out();
    return {out_valid, ZERO, INF, NAN, SNAN};
  endfunction

  task automatic chk(input string name, input logic [4:0] act,
                     input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] in);
    in_valid = v;
    {e_inf, h_1, fz, ez} = in;
  endtask

  // One cycle: drive at negedge, sample #1 after the posedge.
  task automatic step(input string name, input logic v,
                      input logic [3:0] in);
    @(negedge clk);
    drive(v, in);
    @(posedge clk);
    #1;
    ref_valid = v;
    if (v) ref_flags = model(in);
    chk(name, dut_out(), {ref_valid, ref_flags});
  endtask

  // Structural invariants on every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ((ZERO && INF) || (ZERO && NAN) || (INF && NAN) ||
          (SNAN && !NAN)) begin
        errors++;
        $display("FAIL invariant got z%b i%b n%b s%b want exclusive",
                 ZERO, INF, NAN, SNAN);
      end
    end
  end

  initial begin
    tbl[0] = '{4'b0000, 4'b0000};
    tbl[1] = '{4'b1000, 4'b0011};
    tbl[2] = '{4'b1100, 4'b0010};
    tbl[3] = '{4'b0010, 4'b0000};
    tbl[4] = '{4'b0001, 4'b0000};
    tbl[5] = '{4'b1010, 4'b0100};
    tbl[6] = '{4'b0011, 4'b1000};
    tbl[7] = '{4'b1011, 4'b0100};
    tbl[8] = '{4'b1110, 4'b0100};

    // reset with random inputs, clock running
    rst_n = 1'b0;
    drive(1'b1, 4'($urandom));
    #1;
    chk("reset_async0", dut_out(), 5'b0);
    repeat (3) begin
      @(negedge clk);
      drive(1'b1, 4'($urandom));
    end
    #1;
    chk("reset_held", dut_out(), 5'b0);
    ref_flags = '0;
    ref_valid = 1'b0;

    @(negedge clk);
    drive(1'b0, 4'b1010);
    rst_n = 1'b1;
    step("post_reset_idle", 1'b0, 4'b1010);
    step("post_reset_idle2", 1'b0, 4'b1000);

    // directed table
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(1'b1, tbl[i].in);
      @(posedge clk);
      #1;
      chk($sformatf("table%0d", i), dut_out(), {1'b1, tbl[i].exp});
      ref_valid = 1'b1;
      ref_flags = tbl[i].exp;
    end

    // hold: capture INF, then idle with changing inputs
    step("hold_load", 1'b1, 4'b1010);
    for (int i = 0; i < 4; i++) begin
      step($sformatf("hold%0d", i), 1'b0, 4'($urandom));
      chk($sformatf("hold_inf%0d", i), dut_out(), 5'b00100);
    end

    // back-to-back stream
    for (int i = 0; i < 8; i++)
      step($sformatf("stream%0d", i), 1'b1, 4'($urandom));

    // exhaustive
    for (int i = 0; i < 16; i++)
      step($sformatf("exh%0d", i), 1'b1, 4'(i));

    // asynchronous reset mid-stream, away from any edge
    step("pre_reset_load", 1'b1, 4'b1000);
    @(negedge clk);
    drive(1'b1, 4'b1010);
    #1 rst_n = 1'b0;
    #1;
    chk("reset_async_mid", dut_out(), 5'b0);
    @(posedge clk);
    #1;
    chk("reset_discard", dut_out(), 5'b0);
    @(negedge clk);
    drive(1'b0, 4'b1010);
    rst_n = 1'b1;
    ref_flags = '0;
    @(posedge clk);
    #1;
    chk("reset_release", dut_out(), 5'b0);
    ref_valid = 1'b0;
    step("first_capture", 1'b1, 4'b0011);

    // random traffic
    for (int i = 0; i < 200; i++)
      step($sformatf("rand%0d", i), 1'($urandom_range(0, 1)),
           4'($urandom));

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_exception_classifier.md
# fp_exception_classifier

Registered exception classifier for the floating-point adder datapath. It receives per-operand field flags (exponent all-ones, exponent all-zero, fraction zero, fraction MSB) and reports the IEEE-754 special class: zero, infinity, NaN, or signalling NaN. It sits between operand unpacking and the adder's special-case result mux. Results are registered, with a one-cycle latency valid flag.

## Interface
Parameters: none.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  input flags valid this cycle
- e_inf  in  1  exponent field all ones
- h_1  in  1  fraction MSB (quiet bit)
- fz  in  1  fraction field all zero (excluding hidden bit)
- ez  in  1  exponent field all zero
- out_valid  out  1  registered copy of in_valid
- ZERO  out  1  operand is ±0
- INF  out  1  operand is ±infinity
- NAN  out  1  operand is any NaN (quiet or signalling)
- SNAN  out  1  operand is a signalling NaN

## Operation
Decode, evaluated combinationally from the inputs:
- INF = e_inf & fz
- NAN = e_inf & ~fz
- SNAN = e_inf & ~fz & ~h_1
- ZERO = ez & fz & ~e_inf
- e_inf has priority over ez. The illegal combination e_inf=1, ez=1 decodes as INF or NaN, never ZERO.
- ZERO and INF are mutually exclusive.
- ZERO and NAN are mutually exclusive.
- INF and NAN are mutually exclusive.
- SNAN implies NAN.
- ez=1 with fz=0 (subnormal) gives all flags 0.
- Normal numbers (e_inf=0, ez=0) give all flags 0, regardless of fz and h_1.
- h_1 matters only when e_inf=1 and fz=0.

Capture rules:
- When in_valid=1, the decoded flags load into the output registers.
- When in_valid=0, the flag registers hold their previous values.
- out_valid follows in_valid every cycle.

## Timing
- Latency: 1 cycle. Flags decoded from inputs at edge N appear after edge N and stay stable until the next captured input.
- Reset (rst_n=0) is asynchronous. ZERO, INF, NAN, SNAN and out_valid all go to 0 immediately, independent of clk.
- While rst_n=0, inputs are ignored.
- First capture happens on the first rising clk edge at which rst_n=1 and in_valid=1.
- Reset asserted mid-stream discards the pending result. out_valid is 0 on the cycle after reset release unless in_valid=1 at that edge.
- Back-to-back in_valid gives one result per cycle. No backpressure.
- No combinational path from inputs to outputs.

## Structure
- Shared package (fp_pkg) holds:
  - A class enum: CLS_NORM, CLS_ZERO, CLS_SUB, CLS_INF, CLS_QNAN, CLS_SNAN.
  - A function that maps the four flags to this enum.
- One sub-module is natural: fp_class_decode, a purely combinational flag decode.
- The top level contains only the capture registers and the valid pipeline.
- Reuse fp_class_decode for both adder operands.

## Test plan
- Reset: assert rst_n=0 with random inputs -> all outputs 0 asynchronously. Release, no in_valid -> outputs remain 0.
- Quiet/zero cases, each with in_valid=1, results one cycle later with out_valid=1:
  - All inputs 0 -> all flags 0.
  - e_inf=1, fz=0, h_1=0 -> NAN=1, SNAN=1.
  - e_inf=1, h_1=1, fz=0 -> NAN=1, SNAN=0.
- Infinity/zero cases:
  - fz=1 alone -> all flags 0.
  - ez=1, fz=0 -> all flags 0 (subnormal).
  - e_inf=1, fz=1 -> INF=1 only.
  - ez=1, fz=1 -> ZERO=1 only.
- Priority cases:
  - e_inf=1, ez=1, fz=1 -> INF=1, ZERO=0.
  - e_inf=1, h_1=1, fz=1 -> INF=1, NAN=0.
- Hold and throughput:
  - Capture INF, then in_valid=0 with changing inputs -> INF stays 1, out_valid=0.
  - Streaming 8 vectors back-to-back -> 8 consecutive correct results.
- Exhaustive check: all 16 input combinations against the decode equations. Mutual-exclusion and SNAN-implies-NAN assertions checked on every cycle.
